multiport_ram_ctrl: RTL and testbench
=====================================

Name: multiport_ram_ctrl

Overview:
- Parametrised multi-port synchronous RAM: N_WR write ports, N_RD read ports, DATA_W x 2^ADDR_W array.
- Successor to the fixed 32-bit, 2048-deep, 2W/3R pipeline memory.
- Adds sequential clear-on-reset with a busy flag, defined write-write conflict priority, and selectable read-during-write bypass.
- Sits between the pipelined CPU datapath and the frame/picture buffer.

Parameters:
- DATA_W, 32: data word width.
- ADDR_W, 11: address width; DEPTH = 2^ADDR_W.
- N_WR, 2: number of write ports (1..4).
- N_RD, 3: number of read ports (1..8).
- RD_BYPASS, 1: 1 = a read to an address written in the same cycle returns the new data; 0 = returns the old data.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- w_en  in  N_WR  per-port write enable.
- w_adrs  in  N_WR*ADDR_W  packed write addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
- data_in  in  N_WR*DATA_W  packed write data.
- r_en  in  N_RD  per-port read enable.
- r_adrs  in  N_RD*ADDR_W  packed read addresses.
- data_out  out  N_RD*DATA_W  packed registered read data.
- r_valid  out  N_RD  per-port read valid.
- w_valid  out  N_WR  per-port write-committed flag.
- w_conflict  out  1  pulse: two or more enabled write ports targeted the same address.
- busy  out  1  high while the clear sequence runs.

Behaviour:
- Interface: one clock `clk`; `reset` is synchronous and active-high.
- FSM states: CLEAR and RUN.
- Reset (sampled high at a clk edge):
  - State goes to CLEAR, clear pointer goes to 0, busy = 1.
  - data_out, r_valid, w_valid and w_conflict all go to 0.
  - The array itself is not reset in that cycle.
- CLEAR:
  - Each cycle writes 0 to mem[ptr], then ptr increments.
  - When ptr = DEPTH-1 is written, the next state is RUN and busy drops that same edge.
  - busy is high for exactly DEPTH cycles after reset deasserts.
  - All w_en/r_en inputs are ignored: no array update from user ports; r_valid/w_valid/w_conflict stay 0; data_out holds 0.
- Reset reasserted mid-CLEAR or in RUN: the clear restarts at ptr 0.
- RUN write:
  - Port i with w_en[i] = 1 writes mem[w_adrs_i] <= data_in_i.
  - w_valid[i] is high one cycle later if the port committed.
  - Writes to distinct addresses all commit in the same cycle.
- Write conflict (same address on two or more enabled ports):
  - The lowest-index port wins; losing ports do not commit and their w_valid = 0.
  - w_conflict = 1 on the next cycle, otherwise 0.
- RUN read:
  - Latency 1: data_out_j <= mem[r_adrs_j] and r_valid[j] <= 1 when r_en[j] = 1.
  - When r_en[j] = 0: r_valid[j] <= 0 and data_out_j holds its previous value.
- Read-during-write, same address, same cycle:
  - RD_BYPASS = 1: data_out_j gets the winning write's data_in.
  - RD_BYPASS = 0: data_out_j gets the pre-write contents.
- Multiple read ports may read the same address; each gets identical data.
- Address width exactly covers DEPTH, so there is no out-of-range case.
- No combinational path from inputs to outputs.

Test Plan:
1. Reset 1 cycle, then idle.
   - busy high for exactly 2048 cycles (defaults).
   - Afterwards r_en = 3'b111 with addrs 0, 1000, 2047 gives data_out all 0 and r_valid = 3'b111 one cycle later.
2. Mode lockout during clear: during busy, w_en[0] = 1 to adrs 5 with 0xDEADBEEF.
   - w_valid stays 0.
   - After busy drops, reading adrs 5 returns 0.
3. Dual write, then read:
   - Stimulus: write port0 adrs 10 = 0x11111111 and port1 adrs 20 = 0x22222222 in one cycle.
   - Next cycle: w_valid = 2'b11.
   - Read ports 0/1 at 10/20 return 0x11111111 / 0x22222222 with latency 1.
4. Conflict:
   - Stimulus: port0 and port1 both write adrs 7, with 0xAAAA0000 and 0x0000BBBB.
   - Next cycle: w_conflict = 1 and w_valid = 2'b01.
   - Reading adrs 7 returns 0xAAAA0000.
5. Bypass, with mem[3] = 0x5 beforehand:
   - Stimulus: write adrs 3 = 0x9 and read adrs 3 in the same cycle.
   - RD_BYPASS = 1: data_out = 0x9.
   - RD_BYPASS = 0: data_out = 0x5, and the next read returns 0x9.
6. Reset mid-clear and during RUN:
   - Reassert reset at clear ptr 1000: busy remains high for 2048 cycles from the new deassertion.
   - Reset in RUN after writing adrs 10: read of adrs 10 returns 0 once the clear completes.
   - r_valid is 0 throughout the clear.

Source files
------------

// File: rtl/multiport_ram_ctrl.sv
// N_WR-write / N_RD-read synchronous RAM that sweeps itself to zero after reset (busy during the sweep).
// Reads land 1 cycle after r_en; w_valid/w_conflict report 1 cycle after w_en; no backpressure, user ports are ignored while busy.
module multiport_ram_ctrl #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 11,
  parameter int N_WR      = 2,
  parameter int N_RD      = 3,
  parameter int RD_BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_WR-1:0]          w_en,
  input  logic [N_WR*ADDR_W-1:0]   w_adrs,
  input  logic [N_WR*DATA_W-1:0]   data_in,
  input  logic [N_RD-1:0]          r_en,
  input  logic [N_RD*ADDR_W-1:0]   r_adrs,
  output logic [N_RD*DATA_W-1:0]   data_out,
  output logic [N_RD-1:0]          r_valid,
  output logic [N_WR-1:0]          w_valid,
  output logic                     w_conflict,
  output logic                     busy
);

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_W-1:0]       clr_ptr;
  logic [DATA_W-1:0]       mem [0:(1<<ADDR_W)-1];
  logic [N_WR-1:0]         w_commit;
  logic                    conflict;
  logic [N_RD*DATA_W-1:0]  rd_dat;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_CLEAR;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state == ST_CLEAR);
    case (state)
      ST_CLEAR: if (&clr_ptr) state_nxt = ST_RUN;
      default:  state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)                  clr_ptr <= '0;
    else if (state == ST_CLEAR) clr_ptr <= clr_ptr + 1'b1;
  end

  // A port loses if any lower-indexed enabled port targets the same address.
  always_comb begin
    w_commit = '0;
    conflict = 1'b0;
    for (int i = 0; i < N_WR; i++) begin
      if (w_en[i]) begin
        w_commit[i] = 1'b1;
        for (int j = 0; j < N_WR; j++) begin
          if (j < i && w_en[j] &&
              w_adrs[j*ADDR_W +: ADDR_W] == w_adrs[i*ADDR_W +: ADDR_W]) begin
            w_commit[i] = 1'b0;
            conflict    = 1'b1;
          end
        end
      end
    end
  end

  // Committed write addresses are distinct, so at most one bypass source matches.
  always_comb begin
    rd_dat = '0;
    for (int r = 0; r < N_RD; r++) begin
      rd_dat[r*DATA_W +: DATA_W] = mem[r_adrs[r*ADDR_W +: ADDR_W]];
      for (int i = 0; i < N_WR; i++) begin
        if (RD_BYPASS != 0 && w_commit[i] &&
            w_adrs[i*ADDR_W +: ADDR_W] == r_adrs[r*ADDR_W +: ADDR_W])
          rd_dat[r*DATA_W +: DATA_W] = data_in[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == ST_CLEAR) begin
        mem[clr_ptr] <= '0;
      end else begin
        for (int i = 0; i < N_WR; i++)
          if (w_commit[i]) mem[w_adrs[i*ADDR_W +: ADDR_W]] <= data_in[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out   <= '0;
      r_valid    <= '0;
      w_valid    <= '0;
      w_conflict <= 1'b0;
    end else if (state == ST_CLEAR) begin
      r_valid    <= '0;
      w_valid    <= '0;
      w_conflict <= 1'b0;
    end else begin
      w_valid    <= w_commit;
      w_conflict <= conflict;
      r_valid    <= r_en;
      for (int r = 0; r < N_RD; r++)
        if (r_en[r]) data_out[r*DATA_W +: DATA_W] <= rd_dat[r*DATA_W +: DATA_W];
    end
  end

endmodule

// File: tb/tb_multiport_ram_ctrl.sv
// Directed bench: one bypassing and one non-bypassing instance share all inputs.
module tb_multiport_ram_ctrl;

  logic        clk;
  logic        reset;
  logic [1:0]  w_en;
  logic [21:0] w_adrs;
  logic [63:0] data_in;
  logic [2:0]  r_en;
  logic [32:0] r_adrs;

  logic [95:0] data_out, data_out_nb;
  logic [2:0]  r_valid, r_valid_nb;
  logic [1:0]  w_valid, w_valid_nb;
  logic        w_conflict, w_conflict_nb;
  logic        busy, busy_nb;

  int total = 0;
  int bad   = 0;
  int n;
  logic leak;

  multiport_ram_ctrl #(.RD_BYPASS(1)) dut (
    .clk(clk), .reset(reset), .w_en(w_en), .w_adrs(w_adrs), .data_in(data_in),
    .r_en(r_en), .r_adrs(r_adrs), .data_out(data_out), .r_valid(r_valid),
    .w_valid(w_valid), .w_conflict(w_conflict), .busy(busy)
  );

  multiport_ram_ctrl #(.RD_BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .w_en(w_en), .w_adrs(w_adrs), .data_in(data_in),
    .r_en(r_en), .r_adrs(r_adrs), .data_out(data_out_nb), .r_valid(r_valid_nb),
    .w_valid(w_valid_nb), .w_conflict(w_conflict_nb), .busy(busy_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Counts sampled cycles with busy high; optionally pokes a write to adrs 5 mid-sweep.
  task automatic wait_clear(input logic poke, output int cnt, output logic lk);
    cnt = 0;
    lk  = 1'b0;
    while (busy && cnt < 5000) begin
      if (w_valid != 2'b00 || r_valid != 3'b000 || w_conflict || data_out != 96'd0) lk = 1'b1;
      if (poke && cnt == 10) begin
        w_en    = 2'b01;
        w_adrs  = {11'd0, 11'd5};
        data_in = {32'd0, 32'hDEADBEEF};
      end
      cnt++;
      @(negedge clk);
    end
    w_en = 2'b00;
  endtask

  initial begin
    reset = 1'b1; w_en = '0; w_adrs = '0; data_in = '0; r_en = '0; r_adrs = '0;
    @(negedge clk);
    chk("rst_busy",     64'(busy), 64'd1);
    chk("rst_rvalid",   64'(r_valid), 64'd0);
    chk("rst_wvalid",   64'(w_valid), 64'd0);
    chk("rst_conflict", 64'(w_conflict), 64'd0);
    chk("rst_dout",     64'(data_out != 96'd0), 64'd0);

    // Sweep with a lockout write poked in the middle.
    reset = 1'b0;
    r_en  = 3'b111;
    r_adrs = {11'd2047, 11'd1000, 11'd0};
    wait_clear(1'b1, n, leak);
    chk("clear_cycles", 64'(n), 64'd2048);
    chk("clear_quiet",  64'(leak), 64'd0);
    chk("nb_busy_done", 64'(busy_nb), 64'd0);

    @(negedge clk);
    chk("post_clear_dout", 64'(data_out != 96'd0), 64'd0);
    chk("post_clear_rv",   64'(r_valid), 64'h7);

    r_en = 3'b001; r_adrs = {11'd0, 11'd0, 11'd5};
    @(negedge clk);
    chk("lockout_adr5", 64'(data_out[31:0]), 64'd0);
    chk("lockout_rv",   64'(r_valid), 64'h1);

    // Dual write to distinct addresses.
    r_en = 3'b000;
    w_en = 2'b11; w_adrs = {11'd20, 11'd10}; data_in = {32'h22222222, 32'h11111111};
    @(negedge clk);
    chk("dual_wvalid",   64'(w_valid), 64'h3);
    chk("dual_conflict", 64'(w_conflict), 64'd0);
    chk("dual_rv_idle",  64'(r_valid), 64'd0);
    w_en = 2'b00;
    r_en = 3'b011; r_adrs = {11'd0, 11'd20, 11'd10};
    @(negedge clk);
    chk("dual_rd0", 64'(data_out[31:0]),  64'h11111111);
    chk("dual_rd1", 64'(data_out[63:32]), 64'h22222222);
    chk("dual_rv",  64'(r_valid), 64'h3);
    r_en = 3'b000; r_adrs = {11'd5, 11'd5, 11'd5};
    @(negedge clk);
    chk("hold_rd0", 64'(data_out[31:0]), 64'h11111111);
    chk("hold_rv",  64'(r_valid), 64'd0);

    // Same-address write conflict: port 0 wins.
    w_en = 2'b11; w_adrs = {11'd7, 11'd7}; data_in = {32'h0000BBBB, 32'hAAAA0000};
    @(negedge clk);
    chk("conf_flag",   64'(w_conflict), 64'd1);
    chk("conf_wvalid", 64'(w_valid), 64'h1);
    w_en = 2'b00;
    r_en = 3'b100; r_adrs = {11'd7, 11'd0, 11'd0};
    @(negedge clk);
    chk("conf_rd",      64'(data_out[95:64]), 64'hAAAA0000);
    chk("conf_cleared", 64'(w_conflict), 64'd0);

    // Bypass vs. old-data read in the same cycle as a write.
    r_en = 3'b000;
    w_en = 2'b01; w_adrs = {11'd0, 11'd3}; data_in = {32'd0, 32'h5};
    @(negedge clk);
    w_en = 2'b01; w_adrs = {11'd0, 11'd3}; data_in = {32'd0, 32'h9};
    r_en = 3'b111; r_adrs = {11'd3, 11'd3, 11'd3};
    @(negedge clk);
    chk("byp_rd0",   64'(data_out[31:0]),  64'h9);
    chk("byp_rd1",   64'(data_out[63:32]), 64'h9);
    chk("byp_rd2",   64'(data_out[95:64]), 64'h9);
    chk("nobyp_rd0", 64'(data_out_nb[31:0]), 64'h5);
    w_en = 2'b00; r_en = 3'b001;
    @(negedge clk);
    chk("nobyp_next", 64'(data_out_nb[31:0]), 64'h9);

    // Bypass through a conflict returns the winner's data.
    w_en = 2'b11; w_adrs = {11'd12, 11'd12}; data_in = {32'h2, 32'h1};
    r_en = 3'b001; r_adrs = {11'd0, 11'd0, 11'd12};
    @(negedge clk);
    chk("byp_conf",   64'(data_out[31:0]), 64'h1);
    chk("nobyp_conf", 64'(data_out_nb[31:0]), 64'h0);
    w_en = 2'b00; r_en = 3'b000;

    // Reset during RUN, then again at clear pointer 1000.
    reset = 1'b1;
    @(negedge clk);
    chk("run_rst_busy", 64'(busy), 64'd1);
    chk("run_rst_dout", 64'(data_out != 96'd0), 64'd0);
    chk("run_rst_rv",   64'(r_valid), 64'd0);
    reset = 1'b0;
    r_en = 3'b111; r_adrs = {11'd10, 11'd10, 11'd10};
    leak = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (r_valid != 3'b000) leak = 1'b1;
    end
    chk("mid_busy",  64'(busy), 64'd1);
    chk("mid_quiet", 64'(leak), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wait_clear(1'b0, n, leak);
    chk("reclear_cycles", 64'(n), 64'd2048);
    chk("reclear_quiet",  64'(leak), 64'd0);
    @(negedge clk);
    chk("reclear_adr10", 64'(data_out[31:0]), 64'd0);
    chk("reclear_rv",    64'(r_valid), 64'h7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
